// File: rtl/pulse_transmitter_pkg.sv
// rtl/pulse_transmitter_pkg.sv - shared types and symbol field layout for the pulse transmitter
// Purpose: sequencer state encoding and helpers that locate the fields of a
//          symbol word {level, prescaler_sel, duration[TIMER_WIDTH-1:0]}.
// Ports:   none (package).
package pulse_transmitter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  // Output level bit of a symbol word.
  function automatic int sym_level_bit(input int timer_width);
    return timer_width + 1;
  endfunction

  // Prescaler select bit of a symbol word (0 = prescaler A, 1 = prescaler B).
  function automatic int sym_sel_bit(input int timer_width);
    return timer_width;
  endfunction

endpackage

// File: rtl/pulse_transmitter_carrier_gen.sv
// rtl/pulse_transmitter_carrier_gen.sv - carrier square wave generator (only built with PULSE_TRANSMITTER_CARRIER_EN)
// Purpose: free-running 8-bit counter producing a square wave that toggles
//          every half+1 cycles; restart forces the wave high with a fresh count.
// Ports:   clk, rst_n (async active-low), restart, half[7:0] -> carrier.
`ifdef PULSE_TRANSMITTER_CARRIER_EN
module pulse_transmitter_carrier_gen (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       restart,
  input  logic [7:0] half,
  output logic       carrier
);

  logic [7:0] cnt;
  logic       phase;

  assign carrier = phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= 8'd0;
      phase <= 1'b1;
    end else if (restart) begin
      cnt   <= 8'd0;
      phase <= 1'b1;
    end else if (cnt == half) begin
      cnt   <= 8'd0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule
`endif

// File: rtl/pulse_transmitter_countdown_timer.sv
// rtl/pulse_transmitter_countdown_timer.sv - prescaled countdown timer producing one pulse per period
// Purpose: while en=0 the timer keeps loading its parameters; while en=1 it
//          emits pulse_out once every ((duration+1)<<prescaler)+1 cycles and
//          reloads from its inputs on each pulse.
// Ports:   clk, rst_n (async active-low), en, duration, prescaler -> pulse_out.
module pulse_transmitter_countdown_timer #(
  parameter int PRESCALER_WIDTH = 16,
  parameter int TIMER_WIDTH     = 8,
  localparam int PS_W  = $clog2(PRESCALER_WIDTH),
  localparam int CNT_W = TIMER_WIDTH + PRESCALER_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [TIMER_WIDTH-1:0] duration,
  input  logic [PS_W-1:0]        prescaler,
  output logic                   pulse_out
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] reload;

  // Counting reload..0 inclusive gives a period of reload+1 cycles.
  assign reload    = (CNT_W'(duration) + CNT_W'(1)) << prescaler;
  assign pulse_out = en && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || cnt == '0) begin
      cnt <= reload;
    end else begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pulse_transmitter_symbol_sequencer.sv
// rtl/pulse_transmitter_symbol_sequencer.sv - plays a program of timed pulse symbols onto tx_out
// Purpose: IDLE -> PRIME -> RUN sequencer reading symbols from an external
//          store, prefetching each symbol's timing one symbol ahead of the
//          countdown timer, with looping, abort and completion reporting.
//          Optional carrier modulation is built when PULSE_TRANSMITTER_CARRIER_EN
//          is defined (adds cfg_carrier_half).
// Ports:   clk, sys_rst_n (async active-low), start, stop, cfg_* configuration,
//          sym_addr/sym_data symbol store read port, tx_out, busy, done,
//          aborted, cur_index.
module pulse_transmitter_symbol_sequencer
  import pulse_transmitter_pkg::*;
#(
  parameter int PRESCALER_WIDTH = 16,
  parameter int TIMER_WIDTH     = 8,
  parameter int NUM_SYMBOLS     = 16,
  parameter int LOOP_WIDTH      = 8,
  localparam int PS_W  = $clog2(PRESCALER_WIDTH),
  localparam int IDX_W = $clog2(NUM_SYMBOLS)
) (
  input  logic                   clk,
  input  logic                   sys_rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [PS_W-1:0]        cfg_prescaler_a,
  input  logic [PS_W-1:0]        cfg_prescaler_b,
  input  logic [IDX_W-1:0]       cfg_end_index,
  input  logic [LOOP_WIDTH-1:0]  cfg_loop_count,
  input  logic                   cfg_idle_level,
`ifdef PULSE_TRANSMITTER_CARRIER_EN
  input  logic [7:0]             cfg_carrier_half,
`endif
  output logic [IDX_W-1:0]       sym_addr,
  input  logic [TIMER_WIDTH+1:0] sym_data,
  output logic                   tx_out,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic [IDX_W-1:0]       cur_index
);

  localparam int LVL_B = sym_level_bit(TIMER_WIDTH);
  localparam int SEL_B = sym_sel_bit(TIMER_WIDTH);

  state_t                  state;
  logic [TIMER_WIDTH-1:0]  p_dur;
  logic [PS_W-1:0]         p_presc;
  logic                    p_level;
  logic                    cur_lvl;
  logic                    first;
  logic [LOOP_WIDTH-1:0]   loop_remaining;

  logic [TIMER_WIDTH-1:0]  sd_dur;
  logic [PS_W-1:0]         sd_presc;
  logic                    sd_level;
  logic [TIMER_WIDTH-1:0]  t_dur;
  logic [PS_W-1:0]         t_presc;
  logic                    t_en;
  logic                    pulse;
  logic                    lvl_out;
  logic                    last_sym;

  function automatic logic [IDX_W-1:0] nxt(input logic [IDX_W-1:0] i);
    return (i == cfg_end_index) ? '0 : i + IDX_W'(1);
  endfunction

  assign sd_dur   = sym_data[TIMER_WIDTH-1:0];
  assign sd_presc = sym_data[SEL_B] ? cfg_prescaler_b : cfg_prescaler_a;
  assign sd_level = sym_data[LVL_B];

  // The timer loads its parameters on the PRIME->RUN edge, before the p_*
  // registers hold symbol 0, so symbol 0 is fed straight from the store then.
  assign t_dur    = (state == PRIME) ? sd_dur   : p_dur;
  assign t_presc  = (state == PRIME) ? sd_presc : p_presc;
  assign t_en     = (state == RUN);
  assign busy     = (state != IDLE);
  assign last_sym = (cur_index == cfg_end_index);

  pulse_transmitter_countdown_timer #(
    .PRESCALER_WIDTH (PRESCALER_WIDTH),
    .TIMER_WIDTH     (TIMER_WIDTH)
  ) u_timer (
    .clk       (clk),
    .rst_n     (sys_rst_n),
    .en        (t_en),
    .duration  (t_dur),
    .prescaler (t_presc),
    .pulse_out (pulse)
  );

`ifdef PULSE_TRANSMITTER_CARRIER_EN
  logic carrier;

  pulse_transmitter_carrier_gen u_carrier (
    .clk     (clk),
    .rst_n   (sys_rst_n),
    .restart (state == PRIME),
    .half    (cfg_carrier_half),
    .carrier (carrier)
  );

  assign lvl_out = cur_lvl & carrier;
`else
  assign lvl_out = cur_lvl;
`endif

  assign tx_out = (state == RUN) ? lvl_out : cfg_idle_level;

  // First RUN cycle prefetches the symbol after 0; each pulse prefetches the
  // symbol after the one about to become current.
  always_comb begin
    sym_addr = '0;
    if (state == RUN) begin
      sym_addr = first ? nxt(cur_index) : nxt(nxt(cur_index));
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state          <= IDLE;
      p_dur          <= '0;
      p_presc        <= '0;
      p_level        <= 1'b0;
      cur_lvl        <= 1'b0;
      first          <= 1'b0;
      loop_remaining <= '0;
      cur_index      <= '0;
      done           <= 1'b0;
      aborted        <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state          <= PRIME;
            loop_remaining <= cfg_loop_count;
          end
        end
        PRIME: begin
          if (stop) begin
            state   <= IDLE;
            aborted <= 1'b1;
          end else begin
            p_dur     <= sd_dur;
            p_presc   <= sd_presc;
            p_level   <= sd_level;
            cur_lvl   <= sd_level;
            cur_index <= '0;
            first     <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          first <= 1'b0;
          if (stop) begin
            state     <= IDLE;
            aborted   <= 1'b1;
            cur_index <= '0;
          end else if (pulse) begin
            if (last_sym && loop_remaining == '0) begin
              state     <= IDLE;
              done      <= 1'b1;
              cur_index <= '0;
            end else begin
              cur_lvl   <= p_level;
              cur_index <= nxt(cur_index);
              p_dur     <= sd_dur;
              p_presc   <= sd_presc;
              p_level   <= sd_level;
              if (last_sym) begin
                loop_remaining <= loop_remaining - LOOP_WIDTH'(1);
              end
            end
          end else if (first) begin
            p_dur   <= sd_dur;
            p_presc <= sd_presc;
            p_level <= sd_level;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pulse_transmitter_symbol_sequencer.md
Name: pulse_transmitter_symbol_sequencer

Overview:
Sequences a program of pulse symbols through pulse_transmitter_countdown_timer to produce a timed output waveform (e.g. IR/RF-style pulse trains).
- Reads symbols from an external symbol store via a combinational read port.
- Feeds each symbol's duration and prescaler to the timer one cycle ahead.
- Drives the output level, handles program looping, and reports completion.
- Sits between the peripheral register bank and the output pin.

Parameters:
PRESCALER_WIDTH, 16, prescaler range passed to the timer; prescaler select width is $clog2(PRESCALER_WIDTH).
TIMER_WIDTH, 8, symbol duration field width.
NUM_SYMBOLS, 16, symbol store depth; index width IDX_W = $clog2(NUM_SYMBOLS).
LOOP_WIDTH, 8, width of the repeat counter.

Ports:
clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset
start  in  1  1-cycle request to begin transmission; ignored while busy
stop  in  1  1-cycle abort request
cfg_prescaler_a  in  $clog2(PRESCALER_WIDTH)  prescaler used when symbol sel=0
cfg_prescaler_b  in  $clog2(PRESCALER_WIDTH)  prescaler used when symbol sel=1
cfg_end_index  in  IDX_W  index of the last symbol in the program
cfg_loop_count  in  LOOP_WIDTH  extra passes after the first (0 = play once)
cfg_idle_level  in  1  output level when not transmitting
sym_addr  out  IDX_W  symbol store read address
sym_data  in  TIMER_WIDTH+2  {level, prescaler_sel, duration}; valid in the same cycle as sym_addr
tx_out  out  1  transmitted waveform
busy  out  1  high from PRIME through RUN
done  out  1  1-cycle pulse on normal completion
aborted  out  1  1-cycle pulse when stop terminates a transmission
cur_index  out  IDX_W  index of the symbol currently on tx_out

Behaviour:
- Reset (async, sys_rst_n=0) values:
  - state=IDLE, tx_out=cfg_idle_level (combinational from IDLE), busy=0, done=0, aborted=0, cur_index=0, sym_addr=0.
  - Parameter registers are 0; timer en=0.
- State machine IDLE -> PRIME -> RUN -> IDLE:
  - IDLE: timer en=0; tx_out=cfg_idle_level. start=1 (and stop=0) -> PRIME; latch loop_remaining=cfg_loop_count.
  - PRIME (exactly 1 cycle): sym_addr=0; latch p_dur, p_presc (selected by sym_data sel bit) and p_level from symbol 0. Timer en stays 0 so the timer samples its parameters this cycle. -> RUN.
  - RUN, first cycle:
    - en=1; cur_lvl<=p_level; cur_index=0.
    - Prefetch symbol nxt(0) into the p_* registers; the timer only reloads from its inputs on its own pulse.
  - RUN, each timer pulse_out cycle:
    - The timer reloads with the prefetched params.
    - cur_lvl<=p_level; cur_index<=nxt(cur_index); prefetch nxt(nxt(cur_index)).
  - nxt(i): i==cfg_end_index ? 0 : i+1.
  - Wrap from cfg_end_index to 0 decrements loop_remaining.
  - Completion: pulse_out while cur_index==cfg_end_index and loop_remaining==0 -> en=0, done=1 for 1 cycle, IDLE. tx_out returns to idle level in the same cycle done is high.
- tx_out in RUN = cur_lvl.
- Symbol duration: each symbol lasts exactly the timer period ((duration+1)<<prescaler)+1 cycles, measured between consecutive pulse_out events. The first symbol is measured from the first RUN cycle.
- cfg_* and sym_data are sampled only at PRIME and at prefetch points. Mid-run config changes take effect for later prefetches only; they are not retroactive.
- stop in PRIME or RUN: next cycle state=IDLE, en=0, aborted=1 for 1 cycle, done=0. stop in IDLE is ignored.
- start and stop in the same cycle: stop wins; no transmission starts.
- start while busy: ignored.
- cfg_end_index=0: the single symbol repeats cfg_loop_count+1 times.
- cfg_end_index>=NUM_SYMBOLS: wraps via index arithmetic modulo NUM_SYMBOLS; software must not program this.
- Async reset mid-RUN: immediate return to IDLE values; no done or aborted pulse.

Optional Feature:
PULSE_TRANSMITTER_CARRIER_EN
- Defined:
  - Adds input cfg_carrier_half (8 bits) and an 8-bit free-running carrier counter, restarted at each PRIME.
  - While cur_lvl=1, tx_out = carrier square wave toggling every cfg_carrier_half+1 cycles, starting high.
  - cur_lvl=0 and IDLE are unaffected.
- Undefined: no port, no counter; tx_out=cur_lvl.

Decomposition:
- pulse_transmitter_pkg holds:
  - State enum {IDLE, PRIME, RUN}.
  - Symbol field offsets: SYM_LEVEL_BIT=TIMER_WIDTH+1, SYM_SEL_BIT=TIMER_WIDTH, duration slice [TIMER_WIDTH-1:0].
- Instantiates pulse_transmitter_countdown_timer unchanged.
- Natural sub-module: pulse_transmitter_carrier_gen (carrier counter and gating), compiled under the macro.

Test Plan:
- Single pass: symbols {1,0,3},{0,0,1}, prescaler_a=0, end=1, loop=0, idle=0, start -> tx_out high 5 cycles, low 3 cycles, then done pulse, busy=0, tx_out=0.
- Prescaler select: symbol {1,1,1} with prescaler_b=1 -> high for 5 cycles; with prescaler_b=2 -> 9 cycles.
- Looping: end=0, loop=2, symbol {1,0,0} -> three back-to-back 2-cycle symbols, cur_index stays 0, exactly one done pulse.
- Abort: stop on the 3rd RUN cycle -> next cycle aborted=1, done=0, tx_out=cfg_idle_level; a later start restarts from index 0.
- Start+stop same cycle, and start during RUN -> no state change / no restart; waveform unaffected.
- Async reset mid-RUN, then carrier (macro on, cfg_carrier_half=1, level-1 symbol) -> outputs reset immediately; during the high symbol tx_out toggles every 2 cycles.
